// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched {instruction, PC, PC+4} triples feeding decode
module fetch_queue #(
  parameter int INST_Width = 32,
  parameter int DEPTH = 4,
  parameter logic [INST_Width-1:0] NOP_INST = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid_F,
  input  logic [INST_Width-1:0]     i_instr_F,
  input  logic [INST_Width-1:0]     i_PC_F,
  input  logic [INST_Width-1:0]     i_PC_plus4_F,
  output logic                      o_ready_F,
  input  logic                      i_stall_D,
  input  logic                      i_flush,
  output logic                      o_valid_D,
  output logic [INST_Width-1:0]     o_instr_D,
  output logic [INST_Width-1:0]     o_PC_D,
  output logic [INST_Width-1:0]     o_PC_plus4_D,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [INST_Width-1:0] instr_q [DEPTH];
  logic [INST_Width-1:0] pc_q    [DEPTH];
  logic [INST_Width-1:0] pc4_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq;
  // Handshakes, show-ahead head outputs (forced to NOP when empty) and pointer/count next state
  always_comb begin
    o_ready_F    = count_q != CW'(DEPTH);
    o_valid_D    = count_q != '0;
    enq          = i_valid_F & o_ready_F & ~i_flush;
    deq          = o_valid_D & ~i_stall_D & ~i_flush;
    o_instr_D    = o_valid_D ? instr_q[rd_ptr_q] : NOP_INST;
    o_PC_D       = o_valid_D ? pc_q[rd_ptr_q] : '0;
    o_PC_plus4_D = o_valid_D ? pc4_q[rd_ptr_q] : '0;
    o_count      = count_q;
    wr_ptr_d     = i_flush ? '0 : wr_ptr_q + AW'(enq);
    rd_ptr_d     = i_flush ? '0 : rd_ptr_q + AW'(deq);
    count_d      = i_flush ? '0 : count_q + CW'(enq) - CW'(deq);
  end
  // Pointer and occupancy registers; flush is folded into the next-state logic above
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Entry storage, written on enqueue only; left unreset since empty outputs are forced
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr_q] <= i_instr_F;
      pc_q[wr_ptr_q]    <= i_PC_F;
      pc4_q[wr_ptr_q]   <= i_PC_plus4_F;
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (PC register plus instruction memory) and the IF/ID decode boundary.
- Buffers fetched {instruction, PC, PC+4} triples in a circular FIFO.
- Decouples decode stalls from fetch: the PC register's enable is driven from o_ready_F.
- Flushes all contents on a control-flow redirect from execute.

Parameters:
- INST_Width, 32, width of instruction, PC and PC+4 fields.
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, instruction presented on o_instr_D when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid_F  in  1  fetch stage presents a valid triple this cycle.
- i_instr_F  in  INST_Width  fetched instruction.
- i_PC_F  in  INST_Width  PC of the fetched instruction.
- i_PC_plus4_F  in  INST_Width  PC+4 of the fetched instruction.
- o_ready_F  out  1  queue can accept; drives the PC register enable.
- i_stall_D  in  1  decode cannot consume this cycle.
- i_flush  in  1  redirect/flush from execute (taken branch, jump).
- o_valid_D  out  1  head entry is valid.
- o_instr_D  out  INST_Width  head instruction, or NOP_INST when empty.
- o_PC_D  out  INST_Width  head PC, or 0 when empty.
- o_PC_plus4_D  out  INST_Width  head PC+4, or 0 when empty.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - Storage array of DEPTH entries; storage is not reset.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register, $clog2(DEPTH)+1 bits.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Consequently o_valid_D=0, o_instr_D=NOP_INST, o_PC_D=0, o_PC_plus4_D=0, o_count=0, o_ready_F=1.
- o_ready_F = (count != DEPTH).
  - Combinational from count only; no dependence on i_stall_D or i_flush.
  - A full queue refuses a write even if a dequeue happens in the same cycle.
- enq = i_valid_F & o_ready_F & ~i_flush.
- deq = o_valid_D & ~i_stall_D & ~i_flush.
- Outputs are show-ahead: o_valid_D = (count != 0), and the data outputs come combinationally from entry[rd_ptr]. When empty, the data outputs are forced to NOP_INST/0/0.
- Latency: a triple enqueued at edge N appears on the outputs immediately after edge N, provided it is at the head.
- On enq: entry[wr_ptr] <= {i_instr_F, i_PC_F, i_PC_plus4_F}; wr_ptr increments.
- On deq: rd_ptr increments.
- count update:
  - enq only: +1.
  - deq only: -1.
  - both: unchanged. This is legal at any non-full, non-empty occupancy.
  - neither: unchanged.
- Empty with i_valid_F=1 and i_stall_D=0: the entry is written at the edge. No same-cycle bypass; decode sees it the next cycle.
- Flush (i_flush=1 at an edge): wr_ptr=0, rd_ptr=0, count=0.
  - The incoming fetch triple is discarded, and so is the head.
  - Flush has priority over enq, deq and stall.
  - The next cycle shows o_valid_D=0 with NOP_INST on o_instr_D.
- Pointer wrap: a pointer at DEPTH-1 increments to 0; count never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation clears all state immediately, independent of clk; contents are lost.
- i_stall_D while empty has no effect.
- No X propagation from unwritten storage: the empty-case forcing guarantees defined outputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → o_valid_D=0, o_instr_D=32'h00000013, o_PC_D=0, o_count=0, o_ready_F=1.
- Streaming: i_valid_F=1 every cycle with PC=0,4,8,... and i_stall_D=0 → o_PC_D follows the input PC with 1-cycle lag; o_count stays 1; no triple is dropped or duplicated over 20 cycles.
- Fill and backpressure: i_stall_D=1 and push PCs 0x100..0x10C → o_count reaches 4 and o_ready_F=0; a 5th triple (PC 0x110) is not accepted. Then release the stall → outputs 0x100, 0x104, 0x108, 0x10C in order, and o_ready_F=1 after the first dequeue.
- Wrap-around: 10 enqueue/dequeue cycles with DEPTH=4 at occupancy 2 → order preserved across the pointer wrap; o_PC_plus4_D == o_PC_D+4 for every output.
- Flush with a simultaneous push: occupancy 3, then assert i_flush with i_valid_F=1 (PC 0x200) → next cycle o_count=0, o_valid_D=0, and PC 0x200 is never output. A subsequent push of PC 0x300 appears next.
- Asynchronous reset mid-stream: at occupancy 2, drop rst between clock edges → o_count=0 and o_valid_D=0 immediately, without waiting for clk.
